// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display blocks:
// scan state encoding, hex glyph table and index-width helper.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Active-high segment patterns, bit 0 = segment a.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int DIG_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to 7-segment glyph, active-high, purely combinational.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH_TABLE[nib_i];

endmodule

// File: rtl/display_scanner.sv
// Multiplexed N-digit 7-segment scanner with blanking gaps between digits,
// double-buffered digit data and leading-zero suppression.
module display_scanner
  import display_pkg::*;
#(
  parameter int N_DIG       = 4,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1,
  parameter bit ACT_LOW     = 1'b1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Tick,
  input  logic               i_En,
  input  logic               i_Load,
  input  logic [4*N_DIG-1:0] i_Digits,
  input  logic [N_DIG-1:0]   i_Dp,
  input  logic               i_Lz,
  output logic [N_DIG-1:0]   o_An,
  output logic [6:0]         o_Seg,
  output logic               o_Dp,
  output logic               o_Frame
);

  localparam int              DW        = DIG_W(N_DIG);
  localparam logic [DW-1:0]   LAST_IDX  = DW'(N_DIG - 1);
  localparam logic [7:0]      ON_CNT    = 8'(ON_TICKS);
  localparam logic [7:0]      BLANK_CNT = 8'(BLANK_TICKS);
  localparam logic [N_DIG-1:0] AN_OFF   = {N_DIG{ACT_LOW}};
  localparam logic [6:0]      SEG_OFF   = {7{ACT_LOW}};

  scan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0] idx_q, idx_d;
  logic [4*N_DIG-1:0] shadow_dig_q, shadow_dig_d, active_dig_q, active_dig_d;
  logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic frame_q, frame_d;
  logic [N_DIG-1:0] an_q, an_d, an_act;
  logic [6:0]       seg_q, seg_d, seg_act, glyph;
  logic             dp_q, dp_d, dp_act;
  logic [N_DIG-1:0] lz_dark;
  logic             lz_run;
  logic [3:0]       sel_nib;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (!i_En) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          if (BLANK_TICKS == 0) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else if (i_Tick) begin
            if (cnt_inc == BLANK_CNT) begin
              state_d = SHOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        SHOW: begin
          if (i_Tick) begin
            if (cnt_inc == ON_CNT) begin
              state_d = BLANK;
              cnt_d   = '0;
              if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                frame_d = 1'b1;
              end else begin
                idx_d = idx_q + DW'(1);
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Active buffer only changes while idle or in the o_Frame cycle, so a
  // frame is never drawn from two different loads.
  always_comb begin
    shadow_dig_d = i_Load ? i_Digits : shadow_dig_q;
    shadow_dp_d  = i_Load ? i_Dp     : shadow_dp_q;
    active_dig_d = active_dig_q;
    active_dp_d  = active_dp_q;
    if (state_q == IDLE || frame_q) begin
      active_dig_d = shadow_dig_d;
      active_dp_d  = shadow_dp_d;
    end
  end

  // Walk from the most significant digit down; the run breaks at the first
  // non-zero digit or requested decimal point.
  always_comb begin
    lz_run  = 1'b1;
    lz_dark = '0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      lz_run     = lz_run && (active_dig_d[4*k +: 4] == 4'd0) && !active_dp_d[k];
      lz_dark[k] = lz_run && i_Lz && (k != 0);
    end
  end

  assign sel_nib = active_dig_d[{idx_d, 2'b00} +: 4];

  seg7_decode u_decode (
    .nib_i (sel_nib),
    .seg_o (glyph)
  );

  always_comb begin
    an_act  = '0;
    seg_act = '0;
    dp_act  = 1'b0;
    if (state_d == SHOW) begin
      an_act = {{(N_DIG-1){1'b0}}, 1'b1} << idx_d;
      if (!lz_dark[idx_d]) begin
        seg_act = glyph;
        dp_act  = active_dp_d[idx_d];
      end
    end
    an_d  = an_act ^ AN_OFF;
    seg_d = seg_act ^ SEG_OFF;
    dp_d  = dp_act ^ ACT_LOW;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      frame_q      <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= ACT_LOW;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      frame_q      <= frame_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign o_An    = an_q;
  assign o_Seg   = seg_q;
  assign o_Dp    = dp_q;
  assign o_Frame = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// Checks display_scanner against a tick-count timeline model of the scan,
// plus directed scenarios and a BLANK_TICKS=0 instance.
module tb_display_scanner;

  localparam int P = 5;  // BLANK_TICKS + ON_TICKS of the main DUT
  localparam int B = 1;
  localparam logic [6:0] GLY [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk, rst_n, tick, en, load, lz;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  an, an0;
  logic [6:0]  seg, seg0;
  logic        dpo, dpo0, frame, frame0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_scan, m_frame;
  int          m_t;
  logic [15:0] m_sh_dig, m_act_dig;
  logic [3:0]  m_sh_dp, m_act_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;

  display_scanner #(.N_DIG(4), .ON_TICKS(4), .BLANK_TICKS(1), .ACT_LOW(1'b1)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Tick(tick), .i_En(en), .i_Load(load),
    .i_Digits(digits), .i_Dp(dp), .i_Lz(lz),
    .o_An(an), .o_Seg(seg), .o_Dp(dpo), .o_Frame(frame)
  );

  display_scanner #(.N_DIG(4), .ON_TICKS(4), .BLANK_TICKS(0), .ACT_LOW(1'b1)) dut_b0 (
    .i_Clk(clk), .i_Rst(rst_n), .i_Tick(tick), .i_En(en), .i_Load(load),
    .i_Digits(digits), .i_Dp(dp), .i_Lz(lz),
    .o_An(an0), .o_Seg(seg0), .o_Dp(dpo0), .o_Frame(frame0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit lz_dark(input int k);
    if (!lz || k == 0) return 1'b0;
    for (int j = k; j < 4; j++)
      if (m_act_dig[4*j +: 4] != 4'd0 || m_act_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_frame = 0; m_t = 0;
    m_sh_dig = '0; m_act_dig = '0; m_sh_dp = '0; m_act_dp = '0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
  endtask

  // Display is a function of ticks counted since the scan started:
  // each digit owns a slot of P ticks, the first B of which are dark.
  task automatic model_update();
    bit          scan_prev = m_scan;
    bit          frame_prev = m_frame;
    logic [15:0] nsd = load ? digits : m_sh_dig;
    logic [3:0]  nsp = load ? dp : m_sh_dp;
    int          k;
    m_sh_dig = nsd;
    m_sh_dp  = nsp;
    if (!scan_prev || frame_prev) begin
      m_act_dig = nsd;
      m_act_dp  = nsp;
    end
    m_frame = 0;
    if (!en) begin
      m_scan = 0; m_t = 0;
    end else if (!scan_prev) begin
      m_scan = 1; m_t = 0;
    end else if (tick) begin
      m_t++;
      if (m_t % (4 * P) == 0) m_frame = 1;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = m_frame;
    if (m_scan && (m_t % P) >= B) begin
      k = (m_t / P) % 4;
      e_an = ~(4'b0001 << k);
      if (!lz_dark(k)) begin
        e_seg = ~GLY[m_act_dig[4*k +: 4]];
        e_dp  = ~m_act_dp[k];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dpo, e_dp);
    check("frame", frame, e_frame);
  endtask

  task automatic wait_for_an(input logic [3:0] target, input string tag);
    int n = 0;
    while (an !== target && n < 3000) begin
      tick = (n % 3 == 0);
      step();
      n++;
    end
    tick = 1'b0;
    check({tag, "_reached"}, 32'(an === target), 32'd1);
  endtask

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  initial begin
    logic [3:0] seq_q[$];
    logic [3:0] last_an, exp_an;
    logic [6:0] seen_seg [4];
    logic       seen_dp [4];
    int frames, d, n, run, kexp;
    bit prev_on, seen_on, on;

    rst_n = 0; tick = 0; en = 0; load = 0; lz = 0; digits = '0; dp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dpo, 1'b1);
    check("rst_frame", frame, 1'b0);
    rst_n = 1;

    // Basic scan of 1234, tick every 10 clocks
    digits = 16'h1234; load = 1; en = 1;
    step();
    load = 0;
    frames = 0; last_an = 4'hF;
    for (int c = 0; c < 420; c++) begin
      tick = (c % 10 == 9);
      step();
      if (frame) frames++;
      if (an != 4'hF && an != last_an) seq_q.push_back(an);
      last_an = an;
    end
    tick = 0;
    check("frame_cnt", frames, 2);
    check("seq_len", 32'(seq_q.size() >= 4), 1);
    if (seq_q.size() >= 4) begin
      check("seq0", seq_q[0], 4'hE);
      check("seq1", seq_q[1], 4'hD);
      check("seq2", seq_q[2], 4'hB);
      check("seq3", seq_q[3], 4'h7);
    end
    $display("scan 1234: %0d frames, %0d digit changes", frames, seq_q.size());

    // Leading-zero suppression, then with a decimal point on digit 2
    for (int pass = 0; pass < 2; pass++) begin
      digits = 16'h0050; dp = (pass == 0) ? 4'b0000 : 4'b0100; lz = 1; load = 1;
      step();
      load = 0;
      for (int k = 0; k < 4; k++) begin seen_seg[k] = 7'h00; seen_dp[k] = 1'b0; end
      for (int c = 0; c < 400; c++) begin
        tick = (c % 10 == 9);
        step();
        d = digit_of(an);
        if (d >= 0) begin seen_seg[d] = seg; seen_dp[d] = dpo; end
      end
      tick = 0;
      check("lz_d3", seen_seg[3], 7'h7F);
      check("lz_d1", seen_seg[1], 7'h12);
      check("lz_d0", seen_seg[0], 7'h40);
      if (pass == 0) check("lz_d2", seen_seg[2], 7'h7F);
      else begin
        check("lz_d2_dp_seg", seen_seg[2], 7'h40);
        check("lz_d2_dp", seen_dp[2], 1'b0);
      end
      $display("leading zeros pass %0d: segs %h %h %h %h", pass, seen_seg[3], seen_seg[2], seen_seg[1], seen_seg[0]);
    end
    lz = 0; dp = 0;

    // Mid-frame load: model enforces old value until the frame boundary
    wait_for_an(4'hD, "tear_wait");
    digits = 16'hABCD; load = 1;
    step();
    load = 0;
    for (int c = 0; c < 300; c++) begin tick = (c % 4 == 0); step(); end
    $display("mid-frame load of ABCD done");

    // Load coinciding with o_Frame
    n = 0;
    while (frame !== 1'b1 && n < 2000) begin tick = (n % 2 == 0); step(); n++; end
    tick = 0;
    check("frame_seen", frame, 1'b1);
    digits = 16'h5A5A; load = 1;
    step();
    load = 0;
    wait_for_an(4'hE, "coinc_d0");
    check("coinc_seg", seg, 7'h08);
    $display("load on frame: digit0 seg %h", seg);

    // Enable drop while digit 2 is lit
    wait_for_an(4'hB, "en_wait");
    en = 0;
    step();
    check("en_an", an, 4'hF);
    check("en_seg", seg, 7'h7F);
    check("en_frame", frame, 1'b0);
    repeat (3) step();
    en = 1;
    n = 0;
    while (an === 4'hF && n < 200) begin tick = (n % 3 == 0); step(); n++; end
    tick = 0;
    check("en_resume", an, 4'hE);
    $display("enable drop/resume: first anode %h", an);

    // Asynchronous reset in the middle of SHOW
    wait_for_an(4'h7, "rst_wait");
    #2 rst_n = 0;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_dp", dpo, 1'b1);
    check("arst_frame", frame, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    $display("async reset mid-scan applied");

    // Randomised traffic
    for (int c = 0; c < 2500; c++) begin
      tick = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        for (int k = 0; k < 4; k++)
          digits[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) lz = ~lz;
      step();
    end
    load = 0; en = 1;
    $display("random traffic: 2500 cycles");

    // BLANK_TICKS=0 instance with a tick every clock
    en = 0;
    step();
    en = 1; tick = 1;
    run = 0; prev_on = 0; seen_on = 0; kexp = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      on = (an0 !== 4'hF);
      if (on == prev_on) run++;
      else begin
        if (prev_on) check("b0_on_len", run, 4);
        else if (seen_on) check("b0_gap", run, 1);
        if (on) begin
          exp_an = ~(4'b0001 << kexp);
          check("b0_digit", an0, exp_an);
          kexp = (kexp + 1) % 4;
          seen_on = 1;
        end
        run = 1;
      end
      prev_on = on;
    end
    tick = 0;
    check("b0_lit", seen_on, 1);
    $display("blank=0 instance: %0d digits shown", kexp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter N_DIG, default 4: number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter ON_TICKS, default 4: i_Tick pulses each digit stays lit (1..255).
REQ-003 Parameter BLANK_TICKS, default 1: i_Tick pulses all anodes stay off between digits, for anti-ghosting (0..255).
REQ-004 Parameter ACT_LOW, default 1: 1 = o_An/o_Seg/o_Dp active-low, 0 = active-high.
REQ-005 i_Clk  input  1  system clock; all logic on rising edge.
REQ-006 i_Rst  input  1  reset, asynchronous, active-low.
REQ-007 i_Tick  input  1  one-cycle scan-rate pulse from the prescaler.
REQ-008 i_En  input  1  scan enable; 0 forces all digits dark.
REQ-009 i_Load  input  1  one-cycle strobe that captures i_Digits/i_Dp into the shadow buffer.
REQ-010 i_Digits  input  4*N_DIG  hex nibbles; nibble 0 is the least significant (rightmost) digit.
REQ-011 i_Dp  input  N_DIG  decimal-point request per digit.
REQ-012 i_Lz  input  1  leading-zero suppression enable.
REQ-013 o_An  output  N_DIG  registered anode drives, one-hot-active or all-inactive.
REQ-014 o_Seg  output  7  registered segments a..g; bit 0 = a.
REQ-015 o_Dp  output  1  registered decimal-point segment.
REQ-016 o_Frame  output  1  one-cycle pulse when the last digit's SHOW period ends.

Function
REQ-017 FSM states: IDLE, BLANK, SHOW. A tick counter (8 bit) and a digit index (ceil(log2 N_DIG) bits) are kept.
REQ-018 IDLE: anodes inactive. Leave to BLANK with index 0 and counter 0 on the first cycle i_En=1.
REQ-019 BLANK: anodes inactive. Each i_Tick increments the counter. When the counter reaches BLANK_TICKS, go to SHOW and clear the counter. If BLANK_TICKS=0, go to SHOW on the next clock without waiting for a tick.
REQ-020 SHOW: the anode for the index is active and segments show the active-buffer digit. Each i_Tick increments the counter. On the tick that makes the counter equal ON_TICKS: clear the counter, go to BLANK, and increment the index.
REQ-021 Index wrap: when the index is N_DIG-1 at the end of SHOW, it wraps to 0. o_Frame is asserted for exactly one cycle, registered together with the state change.
REQ-022 i_En=0 in any state: next cycle the FSM is in IDLE, anodes and segments are inactive, and the index and counter are cleared. No o_Frame is emitted.
REQ-023 Hex decode uses the standard 0-F glyph table: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71. Values are active-high before polarity is applied.
REQ-024 Leading-zero suppression (i_Lz=1) rules:
- Starting from digit N_DIG-1, a digit is blanked (segments off) while it and every more-significant digit are 0 with Dp clear.
- Digit 0 is never blanked.
- Dp of a blanked digit is off.
REQ-025 Double buffering:
- i_Load writes the shadow buffer.
- The active buffer is updated from the shadow only in the cycle o_Frame is asserted, so no tearing occurs.
- If i_Load coincides with o_Frame, the active buffer receives i_Digits/i_Dp directly.
REQ-026 Register transfer while the FSM is in IDLE: the shadow is copied to active every cycle.
REQ-027 All outputs are registered. Anode, segment and Dp changes appear one clock after the tick or state event that causes them.
REQ-028 ACT_LOW inversion is applied at the output register only. Internal logic is active-high.
REQ-029 i_Tick asserted for several consecutive cycles counts once per cycle. No edge detection is done.

Reset
REQ-030 While i_Rst=0, and immediately (asynchronously):
- State = IDLE; index, counter, shadow and active buffers = 0.
- o_An, o_Seg and o_Dp are inactive for the selected polarity (all ones if ACT_LOW=1).
- o_Frame = 0.
REQ-031 Reset release mid-scan restarts from IDLE. No partial frame or o_Frame pulse occurs.

Structure
REQ-032 A shared package display_pkg holds the following. The prescaler and other display blocks reuse them.
- The state enum (IDLE/BLANK/SHOW).
- The 16-entry glyph table constants.
- The DIG_W width function.
REQ-033 One combinational sub-module, seg7_decode (nibble in, 7 segments out, active-high), is instantiated once for the selected digit.

Verification
REQ-034 Reset: assert i_Rst=0 mid-SHOW -> same cycle o_An=4'hF, o_Seg=7'h7F, o_Dp=1, o_Frame=0 (ACT_LOW=1).
REQ-035 Scan: N_DIG=4, ON=4, BLANK=1, i_Digits=16'h1234, tick every 10 clocks -> anodes cycle 1110,1101,1011,0111 (digits 4,3,2,1), each lit 4 ticks with 1 blank tick between. o_Frame pulses once per 20 ticks.
REQ-036 Leading zeros: i_Digits=16'h0050, i_Dp=0, i_Lz=1 -> digits 3 and 2 are dark, digit 1 shows 0x6D (5), digit 0 shows 0x3F (0). With i_Dp=4'b0100, digit 2 shows 0 and only digit 3 is dark.
REQ-037 Tearing: i_Load with 16'hABCD mid-frame -> the remainder of the frame still shows the old value, and 16'hABCD appears from digit 0 after o_Frame. i_Load coinciding with o_Frame -> the new value is used in the next frame.
REQ-038 Enable: drop i_En during SHOW of digit 2 -> next cycle all anodes are off with no o_Frame. Re-raise i_En -> the scan resumes at digit 0 after BLANK.
REQ-039 BLANK_TICKS=0: SHOW periods are back-to-back, separated by exactly one non-tick clock with anodes off.
